sync_debounce: RTL and testbench



---
 rtl/sync_debounce.sv | 101 ++++++++++
 tb/tb_sync_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - synchroniser plus stability-count debouncer with edge pulses
// Raw din is shifted through SYNC_STAGES flops, then must persist STABLE_CYCLES enabled samples to reach dout.
module sync_debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 10,
  parameter int   CNT_W         = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic dout_n,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   dout_nxt;

  // The synchroniser runs every edge regardless of en so metastability settling is never stalled.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      cnt   <= '0;
      dout  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= dout_nxt & ~dout;
      fall  <= ~dout_nxt & dout;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    case (state)
      IDLE: begin
        if (en && (s != dout)) begin
          if (STABLE_CYCLES == 1) begin
            dout_nxt = s;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = COUNT;
          end
        end
      end
      COUNT: begin
        if (en) begin
          if (s == dout) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            // Terminal compare clears the counter, so it can never wrap.
            dout_nxt  = s;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (state == COUNT);
    dout_n = ~dout;
  end

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed-vector bench for sync_debounce
// Default instance plus a SYNC_STAGES=3, STABLE_CYCLES=1 instance sharing the same stimulus.
module tb_sync_debounce;

  logic clk;
  logic res;
  logic din;
  logic en;
  logic dout, dout_n, rise, fall, busy;
  logic dout2, dout_n2, rise2, fall2, busy2;

  int vecs = 0;
  int errs = 0;

  sync_debounce dut (
    .clk    (clk),
    .res    (res),
    .din    (din),
    .en     (en),
    .dout   (dout),
    .dout_n (dout_n),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  sync_debounce #(
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (1)
  ) dut_fast (
    .clk    (clk),
    .res    (res),
    .din    (din),
    .en     (en),
    .dout   (dout2),
    .dout_n (dout_n2),
    .rise   (rise2),
    .fall   (fall2),
    .busy   (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    res = 1'b1;
    din = 1'b1;
    en  = 1'b1;
    #1;
    vecs++; if (dout !== 1'b0)   begin errs++; $display("FAIL por_dout got %b exp 0", dout); end
    vecs++; if (dout_n !== 1'b1) begin errs++; $display("FAIL por_dout_n got %b exp 1", dout_n); end
    vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL por_busy got %b exp 0", busy); end
    vecs++; if ((rise | fall) !== 1'b0) begin errs++; $display("FAIL por_pulse got %b/%b exp 0/0", rise, fall); end
    @(negedge clk);
    res = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
    #2;
    res = 1'b1;
    #1;
    vecs++; if (dout !== 1'b0)    begin errs++; $display("FAIL async_dout got %b exp 0", dout); end
    vecs++; if (dout_n !== 1'b1)  begin errs++; $display("FAIL async_dout_n got %b exp 1", dout_n); end
    vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL async_busy got %b exp 0", busy); end
    vecs++; if (dut.cnt !== 4'd0) begin errs++; $display("FAIL async_cnt got %0d exp 0", dut.cnt); end
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_step();
    logic eb, ed, er;
    din = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      eb = (k >= 2 && k <= 10);
      ed = (k >= 11);
      er = (k == 11);
      vecs++; if (busy !== eb) begin errs++; $display("FAIL clean_busy k=%0d got %b exp %b", k, busy, eb); end
      vecs++; if (dout !== ed) begin errs++; $display("FAIL clean_dout k=%0d got %b exp %b", k, dout, ed); end
      vecs++; if (rise !== er) begin errs++; $display("FAIL clean_rise k=%0d got %b exp %b", k, rise, er); end
      vecs++; if (fall !== 1'b0) begin errs++; $display("FAIL clean_fall k=%0d got %b exp 0", k, fall); end
    end
  endtask

  task automatic test_fall();
    logic ed, ef;
    din = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      ed = (k < 11);
      ef = (k == 11);
      vecs++; if (dout !== ed)    begin errs++; $display("FAIL fall_dout k=%0d got %b exp %b", k, dout, ed); end
      vecs++; if (dout_n !== ~ed) begin errs++; $display("FAIL fall_dout_n k=%0d got %b exp %b", k, dout_n, ~ed); end
      vecs++; if (fall !== ef)    begin errs++; $display("FAIL fall_pulse k=%0d got %b exp %b", k, fall, ef); end
      vecs++; if (rise !== 1'b0)  begin errs++; $display("FAIL fall_rise k=%0d got %b exp 0", k, rise); end
    end
  endtask

  task automatic test_glitch();
    logic       eb;
    logic [3:0] ec;
    for (int k = 0; k <= 12; k++) begin
      din = (k < 5);
      @(posedge clk);
      @(negedge clk);
      eb = (k >= 2 && k <= 6);
      ec = eb ? 4'(k - 1) : 4'd0;
      vecs++; if (busy !== eb)    begin errs++; $display("FAIL glitch_busy k=%0d got %b exp %b", k, busy, eb); end
      vecs++; if (dut.cnt !== ec) begin errs++; $display("FAIL glitch_cnt k=%0d got %0d exp %0d", k, dut.cnt, ec); end
      vecs++; if (dout !== 1'b0)  begin errs++; $display("FAIL glitch_dout k=%0d got %b exp 0", k, dout); end
      vecs++; if (rise !== 1'b0)  begin errs++; $display("FAIL glitch_rise k=%0d got %b exp 0", k, rise); end
    end
  endtask

  task automatic test_enable_hold();
    logic       eb, ed, er;
    logic [3:0] ec;
    din = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      en = !(k >= 5 && k <= 8);
      @(posedge clk);
      @(negedge clk);
      if (k < 2)       ec = 4'd0;
      else if (k <= 4) ec = 4'(k - 1);
      else if (k <= 8) ec = 4'd3;
      else if (k <= 14) ec = 4'(k - 5);
      else             ec = 4'd0;
      eb = (k >= 2 && k <= 14);
      ed = (k >= 15);
      er = (k == 15);
      vecs++; if (dut.cnt !== ec) begin errs++; $display("FAIL en_cnt k=%0d got %0d exp %0d", k, dut.cnt, ec); end
      vecs++; if (busy !== eb)    begin errs++; $display("FAIL en_busy k=%0d got %b exp %b", k, busy, eb); end
      vecs++; if (dout !== ed)    begin errs++; $display("FAIL en_dout k=%0d got %b exp %b", k, dout, ed); end
      vecs++; if (rise !== er)    begin errs++; $display("FAIL en_rise k=%0d got %b exp %b", k, rise, er); end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    din = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      vecs++; if (dout !== 1'b1) begin errs++; $display("FAIL rmc_dout k=%0d got %b exp 1", k, dout); end
    end
    vecs++; if (dut.cnt !== 4'd5) begin errs++; $display("FAIL rmc_cnt_pre got %0d exp 5", dut.cnt); end
    res = 1'b1;
    #1;
    vecs++; if (dout !== 1'b0)    begin errs++; $display("FAIL rmc_dout got %b exp 0", dout); end
    vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL rmc_busy got %b exp 0", busy); end
    vecs++; if (dut.cnt !== 4'd0) begin errs++; $display("FAIL rmc_cnt got %0d exp 0", dut.cnt); end
    @(negedge clk);
    res = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk);
      @(negedge clk);
      vecs++; if (dout !== 1'b0) begin errs++; $display("FAIL rmc_after_dout k=%0d got %b exp 0", k, dout); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmc_after_busy k=%0d got %b exp 0", k, busy); end
      vecs++; if ((rise | fall) !== 1'b0) begin errs++; $display("FAIL rmc_after_pulse k=%0d got %b/%b exp 0/0", k, rise, fall); end
    end
  endtask

  task automatic test_fast_config();
    logic ed, er;
    din = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      ed = (k >= 3);
      er = (k == 3);
      vecs++; if (dout2 !== ed)   begin errs++; $display("FAIL fast_dout k=%0d got %b exp %b", k, dout2, ed); end
      vecs++; if (rise2 !== er)   begin errs++; $display("FAIL fast_rise k=%0d got %b exp %b", k, rise2, er); end
      vecs++; if (busy2 !== 1'b0) begin errs++; $display("FAIL fast_busy k=%0d got %b exp 0", k, busy2); end
      vecs++; if (fall2 !== 1'b0) begin errs++; $display("FAIL fast_fall k=%0d got %b exp 0", k, fall2); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_fall();
    test_glitch();
    test_enable_hold();
    test_reset_mid_count();
    test_fast_config();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
